// File: rtl/cu_pkg.sv
// cu_pkg: shared types and encodings for the hard-wired CPU control unit.
// States, opcodes, register/ALU function codes and mux source codes live here
// so the sequencer and the output decoder agree on every number.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH_H = 3'd0,
    S_FETCH_L = 3'd1,
    S_EXEC    = 3'd2,
    S_EXEC2   = 3'd3,
    S_HALT    = 3'd4
  } cu_state_t;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_NOT = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LSL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;
  localparam logic [3:0] OP_BRA = 4'hC;
  localparam logic [3:0] OP_BNE = 4'hD;
  localparam logic [3:0] OP_INC = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Register file / address register file operations
  localparam logic [1:0] REG_DEC  = 2'd0;
  localparam logic [1:0] REG_INC  = 2'd1;
  localparam logic [1:0] REG_LOAD = 2'd2;
  localparam logic [1:0] REG_CLR  = 2'd3;

  // ALU function codes
  localparam logic [3:0] ALU_PASS_A = 4'd0;
  localparam logic [3:0] ALU_PASS_B = 4'd1;
  localparam logic [3:0] ALU_NOT_A  = 4'd2;
  localparam logic [3:0] ALU_ADD    = 4'd4;
  localparam logic [3:0] ALU_SUB    = 4'd6;
  localparam logic [3:0] ALU_AND    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_XOR    = 4'd9;
  localparam logic [3:0] ALU_LSL    = 4'd10;
  localparam logic [3:0] ALU_LSR    = 4'd11;

  // Mux A/B source codes
  localparam logic [1:0] MUX_ALU  = 2'd0;
  localparam logic [1:0] MUX_MEM  = 2'd1;
  localparam logic [1:0] MUX_IMM  = 2'd2;
  localparam logic [1:0] MUX_ARFC = 2'd3;

  // ARF output selects and active-low enables
  localparam logic [1:0] ARF_SEL_PC = 2'd1;
  localparam logic [1:0] ARF_SEL_AR = 2'd2;
  localparam logic [1:0] ARF_SEL_SP = 2'd3;
  localparam logic [3:0] EN_NONE    = 4'b1111;
  localparam logic [3:0] EN_PC      = 4'b1110;
  localparam logic [3:0] EN_AR      = 4'b1101;

  // Active-low one-cold enable for RF register R(dst+1)
  function automatic logic [3:0] rf_en(input logic [1:0] dst);
    return ~(4'b0001 << dst);
  endfunction

  // ALU operation for the single-cycle arithmetic/logic opcodes
  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT_A;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_LSL:  return ALU_LSL;
      OP_LSR:  return ALU_LSR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/cu_state_seq.sv
// cu_state_seq: T-state sequencer of the control unit.
// FETCH_H -> FETCH_L -> EXEC, then EXEC2 for memory ops, HALT for HLT,
// otherwise straight back to FETCH_H. HALT is left only through reset.
module cu_state_seq
  import cu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] opcode,
  output logic [2:0] state
);

  cu_state_t state_q;
  cu_state_t state_d;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_FETCH_H;
    else        state_q <= state_d;
  end

  // Next-state selection from the current T-state and opcode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH_H: state_d = S_FETCH_L;
      S_FETCH_L: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_LD || opcode == OP_ST) state_d = S_EXEC2;
        else if (opcode == OP_HLT)              state_d = S_HALT;
        else                                    state_d = S_FETCH_H;
      end
      S_EXEC2:   state_d = S_FETCH_H;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH_H;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hard-wired fetch/decode/execute controller for the 8-bit
// datapath. The sequencer holds the T-state; this level decodes every datapath
// control line from that state and IRout.
// Optional feature macro: CU_BNE_EN enables the conditional branch on opcode
// 0xD; without it 0xD is a three-cycle no-op and Z is ignored.
module cpu_control_unit
  import cu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IRout,
  input  logic        Z,
  output logic        IR_En,
  output logic        IR_LH,
  output logic [1:0]  IR_FunSel,
  output logic [1:0]  RF_FunSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ARF_RegSel,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        Halted
);

  logic [2:0] state_bits;
  cu_state_t  state;
  logic [3:0] opcode;
  logic [1:0] dst;
  logic [1:0] src;
  logic       bne_taken;
  logic       unused_imm;

  assign opcode     = IRout[15:12];
  assign dst        = IRout[11:10];
  assign src        = IRout[9:8];
  assign state      = cu_state_t'(state_bits);
  assign unused_imm = ^IRout[7:0];

`ifdef CU_BNE_EN
  assign bne_taken = ~Z;
`else
  logic unused_z;
  assign bne_taken = 1'b0;
  assign unused_z  = Z;
`endif

  cu_state_seq u_seq (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .opcode (opcode),
    .state  (state_bits)
  );

  // Output decode; held at idle while reset is low so nothing is written
  always_comb begin
    IR_En       = 1'b0;
    IR_LH       = 1'b0;
    IR_FunSel   = 2'd0;
    RF_FunSel   = 2'd0;
    ARF_FunSel  = 2'd0;
    RF_RegSel   = EN_NONE;
    ARF_RegSel  = EN_NONE;
    RF_OutASel  = 2'd0;
    RF_OutBSel  = 2'd0;
    ARF_OutCSel = 2'd0;
    ARF_OutDSel = 2'd0;
    ALU_FunSel  = 4'd0;
    MuxASel     = 2'd0;
    MuxBSel     = 2'd0;
    MuxCSel     = 1'b0;
    Mem_CS      = 1'b0;
    Mem_WR      = 1'b0;
    Halted      = 1'b0;
    if (RST_N) begin
      case (state)
        S_FETCH_H, S_FETCH_L: begin
          ARF_OutDSel = ARF_SEL_PC;
          Mem_CS      = 1'b1;
          IR_En       = 1'b1;
          IR_LH       = (state == S_FETCH_L);
          IR_FunSel   = REG_LOAD;
          ARF_RegSel  = EN_PC;
          ARF_FunSel  = REG_INC;
        end
        S_EXEC: begin
          case (opcode)
            OP_AND, OP_OR, OP_NOT, OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_XOR: begin
              RF_OutASel = dst;
              RF_OutBSel = src;
              ALU_FunSel = alu_code(opcode);
              MuxASel    = MUX_ALU;
              RF_RegSel  = rf_en(dst);
              RF_FunSel  = REG_LOAD;
            end
            OP_LDI: begin
              MuxASel   = MUX_IMM;
              RF_RegSel = rf_en(dst);
              RF_FunSel = REG_LOAD;
            end
            OP_LD, OP_ST: begin
              MuxBSel    = MUX_IMM;
              ARF_RegSel = EN_AR;
              ARF_FunSel = REG_LOAD;
            end
            OP_MOV: begin
              RF_OutBSel = src;
              ALU_FunSel = ALU_PASS_B;
              MuxASel    = MUX_ALU;
              RF_RegSel  = rf_en(dst);
              RF_FunSel  = REG_LOAD;
            end
            OP_BRA: begin
              MuxBSel    = MUX_IMM;
              ARF_RegSel = EN_PC;
              ARF_FunSel = REG_LOAD;
            end
            OP_BNE: begin
              if (bne_taken) begin
                MuxBSel    = MUX_IMM;
                ARF_RegSel = EN_PC;
                ARF_FunSel = REG_LOAD;
              end
            end
            OP_INC: begin
              RF_RegSel = rf_en(dst);
              RF_FunSel = REG_INC;
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          ARF_OutDSel = ARF_SEL_AR;
          Mem_CS      = 1'b1;
          if (opcode == OP_ST) begin
            RF_OutASel = dst;
            MuxCSel    = 1'b0;
            ALU_FunSel = ALU_PASS_A;
            Mem_WR     = 1'b1;
          end else begin
            MuxASel   = MUX_MEM;
            RF_RegSel = rf_en(dst);
            RF_FunSel = REG_LOAD;
          end
        end
        S_HALT:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed checks of the control unit output decode.
// IRout and Z are driven directly; outputs are checked 1 ns after each
// falling clock edge.
module tb_cpu_control_unit;

  logic        CLK;
  logic        RST_N;
  logic [15:0] IRout;
  logic        Z;
  logic        IR_En, IR_LH, MuxCSel, Mem_CS, Mem_WR, Halted;
  logic [1:0]  IR_FunSel, RF_FunSel, ARF_FunSel;
  logic [3:0]  RF_RegSel, ARF_RegSel, ALU_FunSel;
  logic [1:0]  RF_OutASel, RF_OutBSel, ARF_OutCSel, ARF_OutDSel;
  logic [1:0]  MuxASel, MuxBSel;

  int checks = 0;
  int errors = 0;

  cpu_control_unit dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IRout       (IRout),
    .Z           (Z),
    .IR_En       (IR_En),
    .IR_LH       (IR_LH),
    .IR_FunSel   (IR_FunSel),
    .RF_FunSel   (RF_FunSel),
    .ARF_FunSel  (ARF_FunSel),
    .RF_RegSel   (RF_RegSel),
    .ARF_RegSel  (ARF_RegSel),
    .RF_OutASel  (RF_OutASel),
    .RF_OutBSel  (RF_OutBSel),
    .ARF_OutCSel (ARF_OutCSel),
    .ARF_OutDSel (ARF_OutDSel),
    .ALU_FunSel  (ALU_FunSel),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .Halted      (Halted)
  );

  // 10 ns clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ir, input logic z);
    IRout = ir;
    Z     = z;
  endtask

  task automatic nextCycle();
    @(negedge CLK);
    #1;
  endtask

  // Every enable off, as in reset and HALT
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_rf_regsel"}, RF_RegSel, 4'b1111);
    checkOutput({tag, "_arf_regsel"}, ARF_RegSel, 4'b1111);
    checkOutput({tag, "_ir_en"}, IR_En, 1'b0);
    checkOutput({tag, "_mem_cs"}, Mem_CS, 1'b0);
    checkOutput({tag, "_mem_wr"}, Mem_WR, 1'b0);
  endtask

  // Fetch T-state outputs; lh selects T0 (0) or T1 (1)
  task automatic checkFetch(input string tag, input logic lh);
    checkOutput({tag, "_ir_en"}, IR_En, 1'b1);
    checkOutput({tag, "_ir_lh"}, IR_LH, lh);
    checkOutput({tag, "_ir_funsel"}, IR_FunSel, 2'd2);
    checkOutput({tag, "_mem_cs"}, Mem_CS, 1'b1);
    checkOutput({tag, "_mem_wr"}, Mem_WR, 1'b0);
    checkOutput({tag, "_outdsel"}, ARF_OutDSel, 2'd1);
    checkOutput({tag, "_arf_regsel"}, ARF_RegSel, 4'b1110);
    checkOutput({tag, "_arf_funsel"}, ARF_FunSel, 2'd1);
    checkOutput({tag, "_rf_regsel"}, RF_RegSel, 4'b1111);
  endtask

  // Walk T0 and T1, loading ir during T1; returns positioned at T2
  task automatic fetchInstr(input string tag, input logic [15:0] ir, input logic z);
    checkFetch({tag, "_t0"}, 1'b0);
    nextCycle();
    checkFetch({tag, "_t1"}, 1'b1);
    applyStimulus(ir, z);
    nextCycle();
  endtask

  logic [3:0] bneZ0RegSel;
  logic [1:0] bneZ0FunSel;

  initial begin
`ifdef CU_BNE_EN
    bneZ0RegSel = 4'b1110;
    bneZ0FunSel = 2'd2;
`else
    bneZ0RegSel = 4'b1111;
    bneZ0FunSel = 2'd0;
`endif
    RST_N = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    nextCycle();
    checkIdle("reset");
    checkOutput("reset_halted", Halted, 1'b0);

    @(negedge CLK);
    RST_N = 1'b1;
    #1;

    // LDI R4, 0x5A
    fetchInstr("ldi", 16'h8C5A, 1'b0);
    checkOutput("ldi_t2_rf_regsel", RF_RegSel, 4'b0111);
    checkOutput("ldi_t2_muxa", MuxASel, 2'd2);
    checkOutput("ldi_t2_rf_funsel", RF_FunSel, 2'd2);
    checkOutput("ldi_t2_ir_en", IR_En, 1'b0);
    checkOutput("ldi_t2_arf_regsel", ARF_RegSel, 4'b1111);
    nextCycle();

    // ADD R3, R2 then reset during its execute cycle
    fetchInstr("add", 16'h3900, 1'b0);
    checkOutput("add_t2_alu", ALU_FunSel, 4'd4);
    checkOutput("add_t2_outa", RF_OutASel, 2'd2);
    checkOutput("add_t2_outb", RF_OutBSel, 2'd1);
    checkOutput("add_t2_rf_regsel", RF_RegSel, 4'b1011);
    checkOutput("add_t2_muxa", MuxASel, 2'd0);
    checkOutput("add_t2_rf_funsel", RF_FunSel, 2'd2);
    RST_N = 1'b0;
    #1;
    checkIdle("add_rst");
    nextCycle();
    checkIdle("add_rst_hold");
    RST_N = 1'b1;
    #1;

    // ST R1, 0x40
    fetchInstr("st", 16'hA040, 1'b0);
    checkOutput("st_t2_arf_regsel", ARF_RegSel, 4'b1101);
    checkOutput("st_t2_muxb", MuxBSel, 2'd2);
    checkOutput("st_t2_arf_funsel", ARF_FunSel, 2'd2);
    checkOutput("st_t2_mem_cs", Mem_CS, 1'b0);
    nextCycle();
    checkOutput("st_t3_outdsel", ARF_OutDSel, 2'd2);
    checkOutput("st_t3_mem_cs", Mem_CS, 1'b1);
    checkOutput("st_t3_mem_wr", Mem_WR, 1'b1);
    checkOutput("st_t3_alu", ALU_FunSel, 4'd0);
    checkOutput("st_t3_outa", RF_OutASel, 2'd0);
    checkOutput("st_t3_rf_regsel", RF_RegSel, 4'b1111);
    nextCycle();

    // LD R3, 0x30
    fetchInstr("ld", 16'h9830, 1'b0);
    checkOutput("ld_t2_arf_regsel", ARF_RegSel, 4'b1101);
    nextCycle();
    checkOutput("ld_t3_outdsel", ARF_OutDSel, 2'd2);
    checkOutput("ld_t3_mem_cs", Mem_CS, 1'b1);
    checkOutput("ld_t3_mem_wr", Mem_WR, 1'b0);
    checkOutput("ld_t3_muxa", MuxASel, 2'd1);
    checkOutput("ld_t3_rf_regsel", RF_RegSel, 4'b1011);
    nextCycle();

    // BNE 0x20 with Z = 0
    fetchInstr("bne0", 16'hD020, 1'b0);
    checkOutput("bne0_arf_regsel", ARF_RegSel, bneZ0RegSel);
    checkOutput("bne0_arf_funsel", ARF_FunSel, bneZ0FunSel);
    checkOutput("bne0_rf_regsel", RF_RegSel, 4'b1111);
    checkOutput("bne0_mem_cs", Mem_CS, 1'b0);
    nextCycle();

    // BNE 0x20 with Z = 1
    fetchInstr("bne1", 16'hD020, 1'b1);
    checkIdle("bne1");
    nextCycle();

    // BRA 0x10
    fetchInstr("bra", 16'hC010, 1'b0);
    checkOutput("bra_arf_regsel", ARF_RegSel, 4'b1110);
    checkOutput("bra_arf_funsel", ARF_FunSel, 2'd2);
    checkOutput("bra_muxb", MuxBSel, 2'd2);
    nextCycle();

    // INC R2
    fetchInstr("inc", 16'hE400, 1'b0);
    checkOutput("inc_rf_regsel", RF_RegSel, 4'b1101);
    checkOutput("inc_rf_funsel", RF_FunSel, 2'd1);
    nextCycle();

    // MOV R2, R3
    fetchInstr("mov", 16'hB600, 1'b0);
    checkOutput("mov_alu", ALU_FunSel, 4'd1);
    checkOutput("mov_outb", RF_OutBSel, 2'd2);
    checkOutput("mov_rf_regsel", RF_RegSel, 4'b1101);
    nextCycle();

    // HLT, hold for 20 cycles, then reset out of it
    fetchInstr("hlt", 16'hF000, 1'b0);
    checkOutput("hlt_t2_halted", Halted, 1'b0);
    checkIdle("hlt_t2");
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      checkOutput("halt_halted", Halted, 1'b1);
      checkIdle("halt");
    end
    RST_N = 1'b0;
    #1;
    checkOutput("halt_rst_halted", Halted, 1'b0);
    checkIdle("halt_rst");
    nextCycle();
    RST_N = 1'b1;
    #1;
    checkFetch("after_halt_t0", 1'b0);
    checkOutput("after_halt_halted", Halted, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
